axis_operand_align: RTL and testbench

Two-lane AXI-Stream operand aligner placed directly upstream of the ALU subtract stage. Buffers operand A and operand B in independent FIFOs and releases them only as a pair, with both output lanes valid in the same cycle. This guarantees the subtractor, which samples `a.tvalid & b.tvalid` with `tready` tied high, never receives a half-present operand pair. It also provides backpressure, flush and skew diagnostics.

---
 rtl/alu_pkg.sv | 11 +
 rtl/iaxistream.sv | 14 +
 rtl/axis_lane_fifo.sv | 48 ++++
 rtl/axis_operand_align.sv | 83 ++++++++
 tb/tb_axis_operand_align.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath types: default operand width and the aligner FIFO entry layout.
package alu_pkg;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] alu_word_t;

  typedef struct packed {
    logic      last;
    alu_word_t data;
  } align_entry_t;
endpackage

// File: rtl/iaxistream.sv
// Minimal AXI-Stream bundle used between ALU pipeline blocks.
interface IAxiStream #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;

  modport Master (output tdata, tvalid, tlast, tid, input tready);
  modport Slave  (input tdata, tvalid, tlast, tid, output tready);
endinterface

// File: rtl/axis_lane_fifo.sv
// First-word-fall-through lane FIFO; clear wins over push/pop, full never accepts a push.
module axis_lane_fifo #(
  parameter type entry_t = alu_pkg::align_entry_t,
  parameter int  DEPTH   = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  entry_t      wdata,
  output entry_t      rdata,
  output logic [AW:0] lvl,
  output logic        full,
  output logic        empty
);
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            wr, rd;

  assign full  = (lvl == (AW+1)'(DEPTH));
  assign empty = (lvl == '0);
  assign wr    = push & ~full & ~clear;
  assign rd    = pop & ~empty & ~clear;
  assign rdata = mem[rptr];

  // storage is deliberately left unreset; level gates every read
  always_ff @(posedge aclk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      lvl <= lvl + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/axis_operand_align.sv
// Two-lane operand aligner: buffers A/B independently and releases them only as a pair.
module axis_operand_align #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     clear,
  IAxiStream.Slave                 s_a,
  IAxiStream.Slave                 s_b,
  IAxiStream.Master                m_a,
  IAxiStream.Master                m_b,
  output logic [$clog2(DEPTH):0]   lvl_a,
  output logic [$clog2(DEPTH):0]   lvl_b,
  output logic                     skew_err
);
  localparam int NUM_LANES = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [NUM_LANES-1:0]          wdata, rdata;
  logic   [NUM_LANES-1:0]          svalid, rdy, push, full, empty;
  logic   [NUM_LANES-1:0][LW-1:0]  lvl;
  logic                            pv, pop, skew_set;
  logic                            unused_tid;

  assign svalid   = {s_b.tvalid, s_a.tvalid};
  assign wdata[0] = {s_a.tlast, s_a.tdata};
  assign wdata[1] = {s_b.tlast, s_b.tdata};

  // ready holds low through reset and clear; no push into a full lane even when popping
  assign rdy  = {NUM_LANES{aresetn & ~clear}} & ~full;
  assign push = svalid & rdy;
  assign pv   = &(~empty);
  assign pop  = pv & m_a.tready & m_b.tready;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    axis_lane_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
    ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (clear),
      .push    (push[g]),
      .pop     (pop),
      .wdata   (wdata[g]),
      .rdata   (rdata[g]),
      .lvl     (lvl[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  assign skew_set = (full[0] & empty[1]) | (full[1] & empty[0]);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)      skew_err <= 1'b0;
    else if (clear)    skew_err <= 1'b0;
    else if (skew_set) skew_err <= 1'b1;
  end

  assign s_a.tready = rdy[0];
  assign s_b.tready = rdy[1];

  assign m_a.tvalid = pv;
  assign m_a.tdata  = rdata[0].data;
  assign m_a.tlast  = rdata[0].last;
  assign m_a.tid    = '0;
  assign m_b.tvalid = pv;
  assign m_b.tdata  = rdata[1].data;
  assign m_b.tlast  = rdata[1].last;
  assign m_b.tid    = '0;

  assign lvl_a = lvl[0];
  assign lvl_b = lvl[1];

  assign unused_tid = ^{s_a.tid, s_b.tid};
endmodule

// File: tb/tb_axis_operand_align.sv
// Randomized scoreboard bench for axis_operand_align: queue-based lane model checked every cycle.
module tb_axis_operand_align;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic aclk, aresetn, clear;
  logic [$clog2(DEPTH):0] lvl_a, lvl_b;
  logic skew_err;

  IAxiStream #(.DATA_W(DW)) sa();
  IAxiStream #(.DATA_W(DW)) sb();
  IAxiStream #(.DATA_W(DW)) ma();
  IAxiStream #(.DATA_W(DW)) mb();

  axis_operand_align #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .s_a(sa), .s_b(sb), .m_a(ma), .m_b(mb),
    .lvl_a(lvl_a), .lvl_b(lvl_b), .skew_err(skew_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: one queue of {tlast,tdata} per lane plus the sticky skew flag
  logic [DW:0] qa[$];
  logic [DW:0] qb[$];
  bit          m_skew = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input bit va, input bit vb, input bit ra, input bit rb, input bit clr);
    @(posedge aclk); #1;
    sa.tvalid = va; sa.tdata = $urandom; sa.tlast = 1'($urandom_range(0, 1)); sa.tid = 4'($urandom);
    sb.tvalid = vb; sb.tdata = $urandom; sb.tlast = 1'($urandom_range(0, 1)); sb.tid = 4'($urandom);
    ma.tready = ra; mb.tready = rb; clear = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 1, 0);
  endtask

  // monitor: compare outputs to model, then advance model by what the next edge will do
  always @(negedge aclk) begin
    bit pvm, pa, pb, pp;
    if (!aresetn) begin
      qa.delete(); qb.delete(); m_skew = 1'b0;
    end
    pvm = (qa.size() > 0) && (qb.size() > 0);
    check("m_a_tvalid", 64'(ma.tvalid), 64'(pvm));
    check("m_b_tvalid", 64'(mb.tvalid), 64'(pvm));
    check("lvl_a", 64'(lvl_a), 64'(qa.size()));
    check("lvl_b", 64'(lvl_b), 64'(qb.size()));
    check("s_a_tready", 64'(sa.tready), 64'(aresetn && !clear && qa.size() < DEPTH));
    check("s_b_tready", 64'(sb.tready), 64'(aresetn && !clear && qb.size() < DEPTH));
    check("skew_err", 64'(skew_err), 64'(m_skew));
    check("m_a_tid", 64'(ma.tid), 64'(0));
    if (pvm) begin
      check("head_a", 64'({ma.tlast, ma.tdata}), 64'(qa[0]));
      check("head_b", 64'({mb.tlast, mb.tdata}), 64'(qb[0]));
    end
    if (aresetn) begin
      if (clear) begin
        qa.delete(); qb.delete(); m_skew = 1'b0;
      end else begin
        pa = sa.tvalid && qa.size() < DEPTH;
        pb = sb.tvalid && qb.size() < DEPTH;
        pp = pvm && ma.tready && mb.tready;
        if ((qa.size() == DEPTH && qb.size() == 0) || (qb.size() == DEPTH && qa.size() == 0))
          m_skew = 1'b1;
        if (pp) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        if (pa) qa.push_back({sa.tlast, sa.tdata});
        if (pb) qb.push_back({sb.tlast, sb.tdata});
      end
    end
  end

  initial begin
    aresetn = 1'b0; clear = 1'b0;
    sa.tvalid = 0; sa.tdata = '0; sa.tlast = 0; sa.tid = '0;
    sb.tvalid = 0; sb.tdata = '0; sb.tlast = 0; sb.tid = '0;
    ma.tready = 0; mb.tready = 0;
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;

    // single A then delayed B: pair appears only once both present
    cyc(1, 0, 1, 1, 0); sa.tdata = 32'h4040_0000;
    idle(2);
    cyc(0, 1, 1, 1, 0); sb.tdata = 32'h3F80_0000;
    idle(3);

    // 20 back-to-back pairs, pointers wrap
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 1, 0);
    idle(3);

    // fill A only -> skew, then drain with B
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, 0);
    idle(2);

    // hold with m_b not ready, then release
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    idle(4);

    // clear colliding with push and pop
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 60) == 0));

    // async reset mid-stream with data buffered
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", 64'(ma.tvalid), 64'(0));
    check("async_rst_lvl_a", 64'(lvl_a), 64'(0));
    check("async_rst_lvl_b", 64'(lvl_b), 64'(0));
    @(posedge aclk); #3 aresetn = 1'b1;
    for (int i = 0; i < 100; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'b0);
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
